// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared state encoding, width defaults and the ID width helper
//            for the UART TX arbiter.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DONE = 2'b01,
        GAP       = 2'b10
    } state_t;

    // A single requester index still needs one bit on the wire.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector; first asserted request at
//            or after rr_ptr, wrapping modulo NUM_REQ.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    always_comb begin
        int          idx;
        logic [ID_W-1:0] sel;
        idx     = 0;
        sel     = '0;
        winner  = '0;
        any_req = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = off + int'(rr_ptr);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (req[sel]) begin
                winner  = sel;
                any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART transmitter among NUM_REQ byte
//            sources. Packet lock is enabled by UART_ARB_PKT_LOCK_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last,
`endif
    output logic [NUM_REQ-1:0]        req_ack,
    input  logic                      tx_ready,
    input  logic                      tx_done,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [id_w(NUM_REQ)-1:0]  grant_id,
    output logic                      busy
);

    localparam int         ID_W     = id_w(NUM_REQ);
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [7:0]          gap_cnt;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     next_ptr;
    logic                any_req;
    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                pkt_end;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

`ifdef UART_ARB_PKT_LOCK_EN
    logic            locked;
    logic [ID_W-1:0] lock_id;

    // While a packet is open only its owner is visible to the selector.
    assign pick_req = locked ? (req & (NUM_REQ'(1) << lock_id)) : req;
    assign pkt_end  = req_last[winner];
`else
    assign pick_req = req;
    assign pkt_end  = 1'b1;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (pick_req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_onehot = NUM_REQ'(1) << winner;
    assign next_ptr   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gap_cnt  <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            locked   <= 1'b0;
            lock_id  <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            req_ack  <= '0;
            case (state)
                IDLE: begin
                    if (tx_ready && any_req) begin
                        tx_data  <= req_bytes[winner];
                        tx_start <= 1'b1;
                        req_ack  <= win_onehot;
                        grant_id <= winner;
                        if (pkt_end) begin
                            rr_ptr <= next_ptr;
                        end
`ifdef UART_ARB_PKT_LOCK_EN
                        locked   <= !pkt_end;
                        lock_id  <= winner;
`endif
                        state    <= WAIT_DONE;
                        busy     <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level arbitration model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int GAP  = 3;

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic [NREQ-1:0]    req      = '0;
    logic [NREQ*DW-1:0] req_data = '0;
`ifdef UART_ARB_PKT_LOCK_EN
    logic [NREQ-1:0]    req_last = '0;
`endif
    logic [NREQ-1:0]    req_ack;
    logic               tx_ready = 1'b0;
    logic               tx_done  = 1'b0;
    logic               tx_start;
    logic [DW-1:0]      tx_data;
    logic [1:0]         grant_id;
    logic               busy;

    int tests = 0;
    int fails = 0;

    logic [8:0] fifo [NREQ][64];
    int         wr_ptr [NREQ];
    int         rd_ptr [NREQ];

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
`ifdef UART_ARB_PKT_LOCK_EN
        .req_last (req_last),
`endif
        .req_ack  (req_ack),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[5'(i*DW) +: DW] = b;
    endtask

    task automatic wait_start(input int bound, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < bound) begin
            tick();
            n++;
            seen = (tx_start === 1'b1);
        end
    endtask

    task automatic end_frame(input int len);
        repeat (len) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        tests++;
        if (tx_start !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: start=%b busy=%b expected 0 0", tx_start, busy);
        end
        tests++;
        if (req_ack !== 4'b0000) begin
            fails++; $display("FAIL reset_ack: got %b expected 0000", req_ack);
        end
        tests++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            fails++; $display("FAIL reset_data: data=%h id=%0d expected 00 0", tx_data, grant_id);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b start=%b expected 0 0", busy, tx_start);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        set_byte(2, 8'hA5);
        tx_ready = 1'b1;
        tick();
        tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            fails++; $display("FAIL single_start: start=%b data=%h expected 1 a5", tx_start, tx_data);
        end
        tests++;
        if (req_ack !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1) begin
            fails++; $display("FAIL single_grant: ack=%b id=%0d busy=%b expected 0100 2 1", req_ack, grant_id, busy);
        end
        req = 4'b0000;
        tick();
        tests++;
        if (tx_start !== 1'b0 || req_ack !== 4'b0000) begin
            fails++; $display("FAIL single_pulse: start=%b ack=%b expected 0 0000", tx_start, req_ack);
        end
        repeat (18) tick();
        tests++;
        if (tx_data !== 8'hA5 || busy !== 1'b1) begin
            fails++; $display("FAIL single_hold: data=%h busy=%b expected a5 1", tx_data, busy);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tests++;
        if (busy !== (GAP > 0)) begin
            fails++; $display("FAIL single_done: busy=%b expected %b", busy, (GAP > 0));
        end
        for (int g = 1; g <= GAP; g++) begin
            tick();
            tests++;
            if (busy !== (g < GAP)) begin
                fails++; $display("FAIL single_gap: cycle %0d busy=%b expected %b", g, busy, (g < GAP));
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int n;
        bit seen;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_byte(i, 8'(8'h10 + i));
        req      = 4'b1111;
        tx_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_start(12, n, seen);
            tests++;
            if (!seen || n != ((f == 0) ? 1 : GAP + 1)) begin
                fails++; $display("FAIL rr_timing: frame %0d seen=%b cycles=%0d expected %0d", f, seen, n, (f == 0) ? 1 : GAP + 1);
            end
            tests++;
            if (req_ack !== 4'(1 << exp_ord[f])) begin
                fails++; $display("FAIL rr_ack: frame %0d got %b expected %b", f, req_ack, 4'(1 << exp_ord[f]));
            end
            tests++;
            if (grant_id !== 2'(exp_ord[f]) || tx_data !== 8'(8'h10 + exp_ord[f])) begin
                fails++; $display("FAIL rr_grant: frame %0d id=%0d data=%h expected %0d %h", f, grant_id, tx_data, exp_ord[f], 8'(8'h10 + exp_ord[f]));
            end
            tick();
            tests++;
            if (tx_start !== 1'b0 || req_ack !== 4'b0000) begin
                fails++; $display("FAIL rr_pulse: frame %0d start=%b ack=%b expected 0 0000", f, tx_start, req_ack);
            end
            repeat (2) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req = 4'b0000;
        repeat (GAP) tick();
    endtask

    task automatic test_wrap();
        int n;
        bit seen;
        set_byte(3, 8'h33);
        set_byte(0, 8'h30);
        req = 4'b1000;
        wait_start(4, n, seen);
        tests++;
        if (!seen || grant_id !== 2'd3 || req_ack !== 4'b1000) begin
            fails++; $display("FAIL wrap_first: seen=%b id=%0d ack=%b expected 1 3 1000", seen, grant_id, req_ack);
        end
        req = 4'b1001;
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_start(GAP + 4, n, seen);
        tests++;
        if (!seen || req_ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 8'h30) begin
            fails++; $display("FAIL wrap_next: seen=%b ack=%b id=%0d data=%h expected 1 0001 0 30", seen, req_ack, grant_id, tx_data);
        end
        req = 4'b0000;
        end_frame(2);
    endtask

    task automatic test_not_ready();
        req      = 4'b0001;
        set_byte(0, 8'h4E);
        tx_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (tx_start !== 1'b0 || req_ack !== 4'b0000) begin
                fails++; $display("FAIL notready_hold: cycle %0d start=%b ack=%b expected 0 0000", c, tx_start, req_ack);
            end
        end
        tx_ready = 1'b1;
        tick();
        tests++;
        if (tx_start !== 1'b1 || req_ack !== 4'b0001 || tx_data !== 8'h4E) begin
            fails++; $display("FAIL notready_go: start=%b ack=%b data=%h expected 1 0001 4e", tx_start, req_ack, tx_data);
        end
        req = 4'b0000;
        end_frame(2);
    endtask

    task automatic test_reset_midframe();
        req = 4'b0001;
        set_byte(0, 8'h5C);
        set_byte(1, 8'h61);
        tick();
        tests++;
        if (tx_start !== 1'b1 || req_ack !== 4'b0001) begin
            fails++; $display("FAIL midrst_grant: start=%b ack=%b expected 1 0001", tx_start, req_ack);
        end
        req = 4'b0000;
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        tests++;
        if (tx_start !== 1'b0 || req_ack !== 4'b0000 || tx_data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_async: start=%b ack=%b data=%h id=%0d busy=%b expected all zero", tx_start, req_ack, tx_data, grant_id, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0011;
        tick();
        tests++;
        if (tx_start !== 1'b1 || req_ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 8'h5C) begin
            fails++; $display("FAIL midrst_regrant: start=%b ack=%b id=%0d data=%h expected 1 0001 0 5c", tx_start, req_ack, grant_id, tx_data);
        end
        req = 4'b0000;
        end_frame(2);
    endtask

    task automatic test_packet();
`ifdef UART_ARB_PKT_LOCK_EN
        int exp_ord[4] = '{1, 1, 1, 0};
`else
        int exp_ord[4] = '{1, 0, 1, 0};
`endif
        int         sent1;
        int         n;
        bit         seen;
        logic [7:0] exp_b;
        req     = 4'b0000;
        tx_done = 1'b0;
        do_reset();
        tx_ready = 1'b1;
        sent1    = 0;
        set_byte(1, 8'hB0);
        set_byte(0, 8'hC0);
`ifdef UART_ARB_PKT_LOCK_EN
        req_last = 4'b0000;
`endif
        req = 4'b0010;
        for (int f = 0; f < 4; f++) begin
            wait_start(GAP + 4, n, seen);
            exp_b = (exp_ord[f] == 1) ? 8'(8'hB0 + sent1) : 8'hC0;
            tests++;
            if (!seen || req_ack !== 4'(1 << exp_ord[f]) || tx_data !== exp_b) begin
                fails++; $display("FAIL pkt_order: frame %0d seen=%b ack=%b data=%h expected %b %h", f, seen, req_ack, tx_data, 4'(1 << exp_ord[f]), exp_b);
            end
            if (req_ack[1] === 1'b1) begin
                sent1++;
                set_byte(1, 8'(8'hB0 + sent1));
`ifdef UART_ARB_PKT_LOCK_EN
                req_last[1] = (sent1 == 2);
`endif
                if (sent1 == 3) req[1] = 1'b0;
            end
            req[0] = 1'b1;
            repeat (2) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req = 4'b0000;
        repeat (GAP) tick();
    endtask

    task automatic test_random();
        int         mptr, earliest, cyc, done_at, last_gid, w, j, lock_id;
        bit         in_frame, grant, locked;
        logic [7:0] mdata;
        logic [8:0] head;
        req     = 4'b0000;
        tx_done = 1'b0;
        do_reset();
        mptr = 0; earliest = 0; cyc = 0; done_at = 0; last_gid = 0; lock_id = 0;
        in_frame = 1'b0; locked = 1'b0; mdata = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            wr_ptr[i] = 0;
            rd_ptr[i] = 0;
        end
        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (wr_ptr[i] - rd_ptr[i] < 4 && $urandom_range(0, 5) == 0) begin
                    fifo[i][wr_ptr[i] % 64] = {($urandom_range(0, 2) == 0), 8'($urandom)};
                    wr_ptr[i]++;
                end
                head = fifo[i][rd_ptr[i] % 64];
                req[2'(i)] = (wr_ptr[i] != rd_ptr[i]);
                set_byte(i, head[7:0]);
`ifdef UART_ARB_PKT_LOCK_EN
                req_last[2'(i)] = head[8];
`endif
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            tx_done  = in_frame ? (cyc + 1 >= done_at) : ($urandom_range(0, 15) == 0);
            tick();
            cyc++;
            grant = 1'b0;
            w     = 0;
            if (!in_frame && cyc >= earliest && tx_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (!grant && req[2'(j)] && (!locked || j == lock_id)) begin
                        grant = 1'b1;
                        w     = j;
                    end
                end
            end
            if (in_frame && tx_done) begin
                in_frame = 1'b0;
                earliest = cyc + 1 + GAP;
            end
            if (grant) begin
                head = fifo[w][rd_ptr[w] % 64];
                rd_ptr[w]++;
                mdata    = head[7:0];
                last_gid = w;
                in_frame = 1'b1;
                done_at  = cyc + 1 + int'($urandom_range(0, 6));
`ifdef UART_ARB_PKT_LOCK_EN
                locked = !head[8];
                if (head[8]) mptr = (w + 1) % NREQ;
                else         lock_id = w;
`else
                mptr = (w + 1) % NREQ;
`endif
            end
            tests++;
            if (tx_start !== grant) begin
                fails++; $display("FAIL rand_start: cycle %0d got %b expected %b", cyc, tx_start, grant);
            end
            tests++;
            if (req_ack !== (grant ? 4'(1 << w) : 4'b0000)) begin
                fails++; $display("FAIL rand_ack: cycle %0d got %b expected %b", cyc, req_ack, grant ? 4'(1 << w) : 4'b0000);
            end
            tests++;
            if (grant_id !== 2'(last_gid)) begin
                fails++; $display("FAIL rand_id: cycle %0d got %0d expected %0d", cyc, grant_id, last_gid);
            end
            tests++;
            if (busy !== (in_frame || cyc < earliest - 1)) begin
                fails++; $display("FAIL rand_busy: cycle %0d got %b expected %b", cyc, busy, (in_frame || cyc < earliest - 1));
            end
            tests++;
            if (tx_data !== mdata) begin
                fails++; $display("FAIL rand_data: cycle %0d got %h expected %h", cyc, tx_data, mdata);
            end
        end
        req     = 4'b0000;
        tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_not_ready();
        test_reset_midframe();
        test_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
